// File: rtl/multicycle_control.sv
// Moore sequencing FSM for the multi-cycle RV64 datapath: memory handshake with
// timeout watchdog, halt on illegal opcode, retired-instruction counter.
module multicycle_control #(
  parameter int unsigned TIMEOUT   = 16,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           opcode,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 iord,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 pc_write_cond,
  output logic                 pc_source,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic                 reg_write,
  output logic                 mem_to_reg,
  output logic                 halted,
  output logic                 bus_err,
  output logic                 illegal,
  output logic [CNT_WIDTH-1:0] retired,
  output logic [3:0]           state_dbg
);

  // Encoding is visible on state_dbg, so the values are fixed.
  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EXECUTE   = 4'd2,
    S_ALU_WB    = 4'd3,
    S_MEM_ADDR  = 4'd4,
    S_MEM_READ  = 4'd5,
    S_MEM_WB    = 4'd6,
    S_MEM_WRITE = 4'd7,
    S_BRANCH    = 4'd8,
    S_HALT      = 4'd9
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam int unsigned WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(TIMEOUT - 1);

  state_e               state_q, state_d;
  logic [WCW-1:0]       wait_q, wait_d;
  logic [CNT_WIDTH-1:0] retired_q, retired_d;
  logic                 bus_err_q, bus_err_d;
  logic                 illegal_q, illegal_d;
  logic                 is_mem;
  logic                 timeout;
  logic                 retire;

  assign is_mem  = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                   (state_q == S_MEM_WRITE);
  // mem_ready in the final wait cycle takes priority over the timeout.
  assign timeout = is_mem && !mem_ready && (wait_q == WAIT_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      retired_q <= '0;
      bus_err_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
      bus_err_q <= bus_err_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bus_err_d = bus_err_q;
    illegal_d = illegal_q;
    retire    = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d   = S_HALT;
          bus_err_d = 1'b1;
        end
      end
      S_DECODE: begin
        unique case (opcode)
          OP_R, OP_I:        state_d = S_EXECUTE;
          OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
          OP_BRANCH:         state_d = S_BRANCH;
          default: begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_EXECUTE: state_d = S_ALU_WB;
      S_ALU_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_MEM_ADDR: state_d = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ: begin
        if (mem_ready) begin
          state_d = S_MEM_WB;
        end else if (timeout) begin
          state_d   = S_HALT;
          bus_err_d = 1'b1;
        end
      end
      S_MEM_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_MEM_WRITE: begin
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end else if (timeout) begin
          state_d   = S_HALT;
          bus_err_d = 1'b1;
        end
      end
      S_BRANCH: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
    retired_d = retired_q + CNT_WIDTH'(retire);
    // Counter only runs while stalled in the same memory state; any transition clears it.
    wait_d = (is_mem && !mem_ready && (state_d == state_q)) ? wait_q + WCW'(1) : '0;
  end

  always_comb begin
    mem_req       = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    halted        = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: alu_src_b = 2'b11;
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        alu_src_b = (opcode == OP_I) ? 2'b10 : 2'b00;
      end
      S_ALU_WB: reg_write = 1'b1;
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_READ: begin
        mem_req  = 1'b1;
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      default: halted = 1'b0;
    endcase
    if (reset) begin
      mem_req       = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      iord          = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_source     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      reg_write     = 1'b0;
      mem_to_reg    = 1'b0;
      halted        = 1'b0;
    end
  end

  assign bus_err   = bus_err_q;
  assign illegal   = illegal_q;
  assign retired   = retired_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: instruction-level reference expanded into expected
// per-cycle phases; a narrow-counter second instance exercises retired wrap.
module tb_multicycle_control;

  localparam int unsigned SW = 3;
  localparam int P_FETCH = 0, P_DECODE = 1, P_EXEC = 2, P_ALUWB = 3, P_MADDR = 4,
                 P_MREAD = 5, P_MWB = 6, P_MWRITE = 7, P_BRANCH = 8, P_HALT = 9;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                         OP_ST = 7'b0100011, OP_BR = 7'b1100011;

  typedef struct packed {
    logic [3:0] st;
    logic req, rd, wr, iord, irw, pcw, pcwc, pcsrc, asa;
    logic [1:0] asb, aop;
    logic rw, m2r, hlt;
  } ctl_t;

  logic clk = 1'b0, reset = 1'b1, mem_ready = 1'b0;
  logic [6:0] opcode = '0;
  logic mem_req, mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond, pc_source;
  logic alu_src_a, reg_write, mem_to_reg, halted, bus_err, illegal;
  logic [1:0] alu_src_b, alu_op;
  logic [31:0] retired;
  logic [3:0] state_dbg;
  logic s_req, s_rd, s_wr, s_iord, s_irw, s_pcw, s_pcwc, s_pcsrc, s_asa, s_rw, s_m2r, s_hlt;
  logic s_bus, s_ill;
  logic [1:0] s_asb, s_aop;
  logic [SW-1:0] s_ret;
  logic [3:0] s_st;
  ctl_t obs, obs_s;

  int n_chk = 0, n_pass = 0, n_fail = 0;
  logic [31:0] m_ret = '0;
  logic m_bus = 1'b0, m_ill = 1'b0;

  always #5 clk = ~clk;

  multicycle_control #(.TIMEOUT(16), .CNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_source(pc_source), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .halted(halted), .bus_err(bus_err),
    .illegal(illegal), .retired(retired), .state_dbg(state_dbg)
  );

  multicycle_control #(.TIMEOUT(16), .CNT_WIDTH(SW)) dut_small (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(s_req), .mem_read(s_rd), .mem_write(s_wr), .iord(s_iord),
    .ir_write(s_irw), .pc_write(s_pcw), .pc_write_cond(s_pcwc),
    .pc_source(s_pcsrc), .alu_src_a(s_asa), .alu_src_b(s_asb), .alu_op(s_aop),
    .reg_write(s_rw), .mem_to_reg(s_m2r), .halted(s_hlt), .bus_err(s_bus),
    .illegal(s_ill), .retired(s_ret), .state_dbg(s_st)
  );

  assign obs = {state_dbg, mem_req, mem_read, mem_write, iord, ir_write, pc_write,
                pc_write_cond, pc_source, alu_src_a, alu_src_b, alu_op, reg_write,
                mem_to_reg, halted};
  assign obs_s = {s_st, s_req, s_rd, s_wr, s_iord, s_irw, s_pcw, s_pcwc, s_pcsrc, s_asa,
                  s_asb, s_aop, s_rw, s_m2r, s_hlt};

  // Control word each phase must present, written straight from the phase table.
  function automatic ctl_t exp_ctl(input int ph, input logic [6:0] op, input logic rdy);
    ctl_t c = '0;
    c.st = 4'(ph);
    case (ph)
      P_FETCH:  begin c.req = 1; c.rd = 1; c.asb = 2'b01; c.irw = rdy; c.pcw = rdy; end
      P_DECODE: c.asb = 2'b11;
      P_EXEC:   begin c.asa = 1; c.aop = 2'b10; c.asb = (op == OP_I) ? 2'b10 : 2'b00; end
      P_ALUWB:  c.rw = 1;
      P_MADDR:  begin c.asa = 1; c.asb = 2'b10; end
      P_MREAD:  begin c.req = 1; c.rd = 1; c.iord = 1; end
      P_MWB:    begin c.rw = 1; c.m2r = 1; end
      P_MWRITE: begin c.req = 1; c.wr = 1; c.iord = 1; end
      P_BRANCH: begin c.asa = 1; c.aop = 2'b01; c.pcwc = 1; c.pcsrc = 1; end
      P_HALT:   c.hlt = 1;
      default:  c = '0;
    endcase
    return c;
  endfunction

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    n_chk++;
    assert (o === e) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic step(input int ph, input logic [6:0] op, input logic rdy);
    @(negedge clk);
    opcode = op;
    mem_ready = rdy;
    #1;
    chk($sformatf("ctl ph%0d", ph), 64'(obs), 64'(exp_ctl(ph, op, rdy)));
    chk($sformatf("ctl_small ph%0d", ph), 64'(obs_s), 64'(exp_ctl(ph, op, rdy)));
    chk("counters_flags", {27'd0, retired, s_ret, bus_err, illegal, s_bus, s_ill},
        {27'd0, m_ret, m_ret[SW-1:0], m_bus, m_ill, m_bus, m_ill});
  endtask

  task automatic do_reset();
    ctl_t t;
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'($urandom);
    opcode = 7'($urandom);
    #1;
    t = obs;
    t.st = '0;
    chk("reset_strobes", 64'(t), 64'd0);
    t = obs_s;
    t.st = '0;
    chk("reset_strobes_small", 64'(t), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    m_ret = '0;
    m_bus = 1'b0;
    m_ill = 1'b0;
  endtask

  task automatic run_instr(input logic [6:0] op, input int fw, input int mw);
    for (int i = 0; i < fw; i++) step(P_FETCH, 7'($urandom), 1'b0);
    step(P_FETCH, 7'($urandom), 1'b1);
    step(P_DECODE, op, 1'($urandom));
    case (op)
      OP_R, OP_I: begin
        step(P_EXEC, op, 1'($urandom));
        step(P_ALUWB, op, 1'($urandom));
      end
      OP_LD: begin
        step(P_MADDR, op, 1'($urandom));
        for (int i = 0; i < mw; i++) step(P_MREAD, op, 1'b0);
        step(P_MREAD, op, 1'b1);
        step(P_MWB, op, 1'($urandom));
      end
      OP_ST: begin
        step(P_MADDR, op, 1'($urandom));
        for (int i = 0; i < mw; i++) step(P_MWRITE, op, 1'b0);
        step(P_MWRITE, op, 1'b1);
      end
      default: step(P_BRANCH, op, 1'($urandom));
    endcase
    m_ret = m_ret + 32'd1;
  endtask

  task automatic mem_timeout(input logic [6:0] op);
    step(P_FETCH, 7'($urandom), 1'b1);
    step(P_DECODE, op, 1'b0);
    step(P_MADDR, op, 1'b0);
    for (int i = 0; i < 16; i++) step((op == OP_LD) ? P_MREAD : P_MWRITE, op, 1'b0);
    m_bus = 1'b1;
    for (int i = 0; i < 4; i++) step(P_HALT, op, 1'($urandom));
    do_reset();
  endtask

  initial begin
    logic [6:0] ops [5] = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR};
    logic [6:0] bad;
    do_reset();

    run_instr(OP_R, 0, 0);
    run_instr(OP_LD, 0, 3);
    run_instr(OP_ST, 0, 0);
    run_instr(OP_BR, 0, 0);

    for (int n = 0; n < 40; n++)
      run_instr(ops[$urandom_range(0, 4)], $urandom_range(0, 4), $urandom_range(0, 4));

    // Watchdog in FETCH: 16 stalled cycles, then HALT with bus_err.
    for (int i = 0; i < 16; i++) step(P_FETCH, 7'($urandom), 1'b0);
    m_bus = 1'b1;
    for (int i = 0; i < 4; i++) step(P_HALT, 7'($urandom), 1'($urandom));
    do_reset();
    // mem_ready on the 16th cycle wins over the timeout.
    run_instr(OP_R, 15, 0);
    run_instr(OP_LD, 0, 15);
    run_instr(OP_ST, 2, 15);
    mem_timeout(OP_LD);
    mem_timeout(OP_ST);

    // Illegal opcode halts with all strobes low.
    do begin
      bad = 7'($urandom);
    end while (bad == OP_R || bad == OP_I || bad == OP_LD || bad == OP_ST || bad == OP_BR);
    run_instr(OP_BR, 1, 0);
    step(P_FETCH, 7'($urandom), 1'b1);
    step(P_DECODE, 7'b1111111, 1'b1);
    m_ill = 1'b1;
    for (int i = 0; i < 20; i++) step(P_HALT, 7'b1111111, 1'($urandom));
    do_reset();
    step(P_FETCH, 7'($urandom), 1'b1);
    step(P_DECODE, bad, 1'b0);
    m_ill = 1'b1;
    for (int i = 0; i < 3; i++) step(P_HALT, bad, 1'($urandom));
    do_reset();

    // Reset in the middle of a MEM_READ wait aborts the access.
    run_instr(OP_R, 0, 0);
    step(P_FETCH, 7'($urandom), 1'b1);
    step(P_DECODE, OP_LD, 1'b0);
    step(P_MADDR, OP_LD, 1'b0);
    step(P_MREAD, OP_LD, 1'b0);
    step(P_MREAD, OP_LD, 1'b0);
    do_reset();
    step(P_FETCH, 7'($urandom), 1'b0);
    run_instr(OP_ST, 13, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style sequencing FSM for the multi-cycle variant of the 64-bit RISC-V-encoded core.
- Replaces the single-cycle combinational control decode. Steps the shared datapath through fetch/decode/execute/memory/writeback.
- Handshakes with a unified instruction/data memory that has variable latency.
- Provides a memory-timeout watchdog, a halt on illegal opcode, and a retired-instruction counter.

Parameters:
- TIMEOUT, 16: max consecutive wait cycles (mem_req=1, mem_ready=0) in one memory state before bus error.
- CNT_WIDTH, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  7  instruction[6:0] from the IR; stable from DECODE until the next FETCH.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- mem_read  out  1  read access.
- mem_write  out  1  write access.
- iord  out  1  address select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load the IR.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load gated by ALU zero in the datapath.
- pc_source  out  1  PC source: 0 = ALU result, 1 = ALUOut (branch target).
- alu_src_a  out  1  ALU A select: 0 = PC (old PC in DECODE), 1 = rs1.
- alu_src_b  out  2  ALU B select: 00 = rs2, 01 = 4, 10 = imm, 11 = imm<<1.
- alu_op  out  2  ALU op: 00 = add, 01 = sub, 10 = funct-decoded.
- reg_write  out  1  register file write enable.
- mem_to_reg  out  1  writeback select: 0 = ALUOut, 1 = MDR.
- halted  out  1  FSM is in HALT.
- bus_err  out  1  sticky memory-timeout flag.
- illegal  out  1  sticky unsupported-opcode flag.
- retired  out  CNT_WIDTH  count of completed instructions.
- state_dbg  out  4  current state encoding.

Behaviour:
- Reset:
  - state <= FETCH; wait counter, retired, bus_err and illegal all <= 0.
  - While reset=1, every strobe output is forced to 0.
- Outputs are decoded from the state; only handshake-dependent strobes also use mem_ready.
- Any output not listed for a state is 0.
- States and transitions:
  - FETCH: mem_req=1, mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=0.
    - ir_write = pc_write = mem_ready.
    - Go to DECODE on mem_ready; otherwise stay.
  - DECODE (1 cycle): alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next state by opcode:
    - 0110011 or 0010011 -> EXECUTE.
    - 0000011 or 0100011 -> MEM_ADDR.
    - 1100011 -> BRANCH.
    - any other -> HALT, with illegal <= 1.
  - EXECUTE (1 cycle): alu_src_a=1, alu_op=10; alu_src_b=00 for 0110011, 10 for 0010011. Next: ALU_WB.
  - ALU_WB (1 cycle): reg_write=1, mem_to_reg=0. Next: FETCH; retired++.
  - MEM_ADDR (1 cycle): alu_src_a=1, alu_src_b=10, alu_op=00. Next: MEM_READ for 0000011, MEM_WRITE for 0100011.
  - MEM_READ: mem_req=1, mem_read=1, iord=1. Go to MEM_WB on mem_ready.
  - MEM_WB (1 cycle): reg_write=1, mem_to_reg=1. Next: FETCH; retired++.
  - MEM_WRITE: mem_req=1, mem_write=1, iord=1. Go to FETCH on mem_ready; retired++ that cycle.
  - BRANCH (1 cycle): alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=1. Next: FETCH; retired++.
  - HALT: all strobes 0, halted=1. Exit only via reset.
- Cycle counts with zero-wait memory: R/I-ALU = 4, load = 5, store = 4, branch = 3.
- Memory states are FETCH, MEM_READ and MEM_WRITE:
  - mem_req and its read/write qualifier stay asserted, unchanged, until the mem_ready cycle.
  - The wait counter clears on entry to any memory state and on mem_ready.
  - It increments on each cycle with mem_ready=0.
  - When it reaches TIMEOUT-1 while mem_ready is still 0: next state HALT, bus_err <= 1.
  - mem_ready arriving in that same cycle wins: normal transition, no error.
- mem_ready outside memory states is ignored.
- retired wraps from 2^CNT_WIDTH-1 to 0.
- Reset mid-access (including mid-wait) aborts the access: next cycle is FETCH, sticky flags cleared.

Test Plan:
- Zero-wait memory (mem_ready=1), opcode 0110011 after reset -> states FETCH, DECODE, EXECUTE, ALU_WB, FETCH; reg_write=1 only in cycle 4; retired=1.
- Load 0000011, mem_ready low for 3 cycles in MEM_READ -> mem_req/mem_read/iord held for 4 cycles; then MEM_WB with mem_to_reg=1; total 8 cycles; retired=1.
- Store 0100011 then branch 1100011, zero-wait -> mem_write pulses exactly 1 cycle; BRANCH asserts pc_write_cond=1, pc_source=1, alu_op=01; retired=2 after 7 cycles.
- Opcode 1111111 at DECODE -> HALT next cycle; halted=1, illegal=1, all strobes 0 for 20 cycles; reset -> FETCH, flags 0.
- mem_ready held 0 in FETCH with TIMEOUT=16 -> HALT after 16 FETCH cycles, bus_err=1. Repeat with mem_ready=1 on the 16th cycle -> DECODE, bus_err=0.
- Reset pulse during the MEM_READ wait -> next cycle FETCH with mem_req=1, iord=0; retired=0.
